// File: rtl/condicionador_botoes_pkg.sv
// Shared types and default constants for the push-button conditioning stage.
// State codes double as the db_estado value shown on the debug display.
package condicionador_pkg;

    typedef enum logic [2:0] {
        ESPERA = 3'd0,
        FILTRA = 3'd1,
        VALIDA = 3'd2,
        SEGURA = 3'd3
    } estado_t;

    localparam int N_BOTOES_PADRAO        = 4;
    localparam int DEBOUNCE_CICLOS_PADRAO = 3;
    localparam int PRESO_CICLOS_PADRAO    = 1000;

endpackage

// File: rtl/condicionador_botoes_sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, async active-low reset to 0.
module sincronizador_2ff #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);

    logic [LARGURA-1:0] s1;
    logic [LARGURA-1:0] s2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/condicionador_botoes.sv
// Synchronises and debounces the button vector, emitting a registered play code and a one-cycle pulse.
// Optional stuck-button detection is enabled by defining BOTAO_PRESO_EN.
module condicionador_botoes
    import condicionador_pkg::*;
#(
    parameter int N_BOTOES        = N_BOTOES_PADRAO,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
    parameter int PRESO_CICLOS    = PRESO_CICLOS_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                tem_jogada,
    output logic [N_BOTOES-1:0] jogada,
    output logic                multipla,
    output logic [2:0]          db_estado,
    output logic                botao_preso
);

    localparam int CNT_MAX = (DEBOUNCE_CICLOS > PRESO_CICLOS) ? DEBOUNCE_CICLOS : PRESO_CICLOS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] UM     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LIM_DB = CNT_W'(DEBOUNCE_CICLOS);

    function automatic logic [CNT_W-1:0] incr_sat(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + UM;
    endfunction

    logic [N_BOTOES-1:0] s2;

    sincronizador_2ff #(
        .LARGURA (N_BOTOES)
    ) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (s2)
    );

    estado_t             estado, prox_estado;
    logic [CNT_W-1:0]    cnt, prox_cnt;
    logic [N_BOTOES-1:0] amostra, prox_amostra;
    logic [N_BOTOES-1:0] prox_jogada;
    logic                prox_tem, prox_multipla;
    logic                varios;
    int unsigned         n_ativos;

    always_comb begin
        n_ativos = 0;
        for (int unsigned i = 0; i < N_BOTOES; i++) begin
            n_ativos += {31'd0, amostra[i]};
        end
        varios = (n_ativos > 1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= ESPERA;
            cnt        <= '0;
            amostra    <= '0;
            tem_jogada <= 1'b0;
            jogada     <= '0;
            multipla   <= 1'b0;
        end else begin
            estado     <= prox_estado;
            cnt        <= prox_cnt;
            amostra    <= prox_amostra;
            tem_jogada <= prox_tem;
            jogada     <= prox_jogada;
            multipla   <= prox_multipla;
        end
    end

    // Outputs are loaded on the edge that enters VALIDA, so the pulse spans exactly the VALIDA cycle.
    always_comb begin
        prox_estado   = estado;
        prox_cnt      = cnt;
        prox_amostra  = amostra;
        prox_tem      = 1'b0;
        prox_jogada   = jogada;
        prox_multipla = multipla;
        case (estado)
            ESPERA: begin
                if (s2 != '0) begin
                    prox_estado  = FILTRA;
                    prox_amostra = s2;
                    prox_cnt     = UM;
                end
            end
            FILTRA: begin
                if (s2 == '0) begin
                    prox_estado = ESPERA;
                    prox_cnt    = '0;
                end else if (s2 != amostra) begin
                    prox_amostra = s2;
                    prox_cnt     = UM;
                end else begin
                    prox_cnt = incr_sat(cnt);
                    if (prox_cnt >= LIM_DB) begin
                        prox_estado = VALIDA;
                        prox_cnt    = '0;
                        if (habilita) begin
                            prox_tem      = 1'b1;
                            prox_jogada   = amostra;
                            prox_multipla = varios;
                        end
                    end
                end
            end
            VALIDA: begin
                prox_estado = SEGURA;
                prox_cnt    = '0;
            end
            SEGURA: begin
                if (s2 == '0) begin
                    prox_cnt = incr_sat(cnt);
                    if (prox_cnt >= LIM_DB) begin
                        prox_estado = ESPERA;
                        prox_cnt    = '0;
                    end
                end else begin
                    prox_cnt = '0;
                end
            end
            default: begin
                prox_estado = ESPERA;
                prox_cnt    = '0;
            end
        endcase
    end

    assign db_estado = estado;

`ifdef BOTAO_PRESO_EN
    localparam logic [CNT_W-1:0] LIM_PRESO = CNT_W'(PRESO_CICLOS);

    logic [CNT_W-1:0] cnt_preso;
    logic             preso;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_preso <= '0;
            preso     <= 1'b0;
        end else if (prox_estado == ESPERA) begin
            cnt_preso <= '0;
            preso     <= 1'b0;
        end else if (estado == SEGURA && s2 != '0 && cnt_preso < LIM_PRESO) begin
            cnt_preso <= cnt_preso + UM;
            if (cnt_preso + UM >= LIM_PRESO) begin
                preso <= 1'b1;
            end
        end
    end

    assign botao_preso = preso;
`else
    assign botao_preso = 1'b0;
`endif

endmodule

// File: tb/tb_condicionador_botoes.sv
// Self-checking bench for condicionador_botoes: directed test-plan steps plus random bursts
// compared every cycle against a run-length reference model.
module tb_condicionador_botoes;

    localparam int N = 4;
    localparam int D = 3;
    localparam int P = 1000;
`ifdef BOTAO_PRESO_EN
    localparam bit PRESO_EN = 1'b1;
`else
    localparam bit PRESO_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         habilita = 1'b1;
    logic [N-1:0] botoes = '0;
    logic         tem_jogada;
    logic [N-1:0] jogada;
    logic         multipla;
    logic [2:0]   db_estado;
    logic         botao_preso;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [N-1:0] fila[$];
    bit           armado;
    bit           valida_ciclo;
    int           run;
    int           cnt_preso;
    logic [N-1:0] amostra_m;
    logic         exp_tem;
    logic [N-1:0] exp_jog;
    logic         exp_mult;
    logic         exp_preso;
    int           pulsos;

    condicionador_botoes #(
        .N_BOTOES        (N),
        .DEBOUNCE_CICLOS (D),
        .PRESO_CICLOS    (P)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .habilita    (habilita),
        .botoes      (botoes),
        .tem_jogada  (tem_jogada),
        .jogada      (jogada),
        .multipla    (multipla),
        .db_estado   (db_estado),
        .botao_preso (botao_preso)
    );

    always #5 clock = ~clock;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        assert (obs === esp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, esp, $time);
        end
    endtask

    task automatic modelo_reset();
        fila = {};
        fila.push_back('0);
        fila.push_back('0);
        armado = 1'b1;
        valida_ciclo = 1'b0;
        run = 0;
        cnt_preso = 0;
        amostra_m = '0;
        exp_tem = 1'b0;
        exp_jog = '0;
        exp_mult = 1'b0;
        exp_preso = 1'b0;
    endtask

    // A press is accepted after D identical nonzero samples; the acceptance cycle ignores its
    // sample, then D consecutive zero samples re-arm detection.
    task automatic modelo_passo(input logic [N-1:0] s, input logic hab);
        exp_tem = 1'b0;
        if (valida_ciclo) begin
            valida_ciclo = 1'b0;
            run = 0;
        end else if (armado) begin
            if (s == '0) begin
                run = 0;
            end else if (run > 0 && s == amostra_m) begin
                run++;
            end else begin
                amostra_m = s;
                run = 1;
            end
            if (run >= D) begin
                armado = 1'b0;
                valida_ciclo = 1'b1;
                run = 0;
                if (hab) begin
                    exp_tem = 1'b1;
                    exp_jog = amostra_m;
                    exp_mult = ($countones(amostra_m) > 1);
                end
            end
        end else begin
            if (s == '0) begin
                run++;
            end else begin
                run = 0;
                if (PRESO_EN && cnt_preso < P) begin
                    cnt_preso++;
                    if (cnt_preso >= P) exp_preso = 1'b1;
                end
            end
            if (run >= D) begin
                armado = 1'b1;
                run = 0;
                cnt_preso = 0;
                exp_preso = 1'b0;
            end
        end
    endtask

    function automatic logic [2:0] estado_esperado();
        if (valida_ciclo) return 3'd2;
        if (!armado)      return 3'd3;
        if (run > 0)      return 3'd1;
        return 3'd0;
    endfunction

    task automatic ciclo(input logic [N-1:0] b, input logic h);
        logic [N-1:0] s;
        @(negedge clock);
        botoes = b;
        habilita = h;
        fila.push_back(b);
        @(posedge clock);
        s = fila.pop_front();
        modelo_passo(s, h);
        #1;
        if (exp_tem) pulsos++;
        confere("tem_jogada", 32'(tem_jogada), 32'(exp_tem));
        confere("jogada", 32'(jogada), 32'(exp_jog));
        confere("multipla", 32'(multipla), 32'(exp_mult));
        confere("db_estado", 32'(db_estado), 32'(estado_esperado()));
        confere("botao_preso", 32'(botao_preso), 32'(exp_preso));
    endtask

    task automatic repete(input logic [N-1:0] b, input logic h, input int n);
        for (int i = 0; i < n; i++) ciclo(b, h);
    endtask

    task automatic confere_zerado(input string tag);
        confere({tag, "_tem"}, 32'(tem_jogada), 32'd0);
        confere({tag, "_jogada"}, 32'(jogada), 32'd0);
        confere({tag, "_multipla"}, 32'(multipla), 32'd0);
        confere({tag, "_estado"}, 32'(db_estado), 32'd0);
        confere({tag, "_preso"}, 32'(botao_preso), 32'd0);
    endtask

    initial begin
        int p0;
        logic [N-1:0] v;
        modelo_reset();
        pulsos = 0;
        #3;
        confere_zerado("reset_inicial");
        @(posedge clock);
        #2;
        reset = 1'b1;

        // clean single press: pulse on 5th edge after apply
        p0 = pulsos;
        ciclo(4'b0001, 1'b1);
        repete(4'b0001, 1'b1, 3);
        confere("latencia_pre", 32'(pulsos - p0), 32'd0);
        ciclo(4'b0001, 1'b1);
        confere("latencia_edge5", 32'(tem_jogada), 32'd1);
        repete(4'b0001, 1'b1, 5);
        repete(4'b0000, 1'b1, 8);
        confere("pulso_unico", 32'(pulsos - p0), 32'd1);

        // bounce on press
        p0 = pulsos;
        repete(4'b0010, 1'b1, 2);
        ciclo(4'b0000, 1'b1);
        repete(4'b0010, 1'b1, 10);
        repete(4'b0000, 1'b1, 6);
        confere("bounce_pulsos", 32'(pulsos - p0), 32'd1);
        confere("bounce_jogada", 32'(jogada), 32'b0010);

        // multi-button then single
        repete(4'b1111, 1'b1, 10);
        confere("multipla_1111", 32'(multipla), 32'd1);
        repete(4'b0000, 1'b1, 6);
        repete(4'b0100, 1'b1, 10);
        confere("multipla_0100", 32'(multipla), 32'd0);
        repete(4'b0000, 1'b1, 6);

        // release glitch: no second pulse
        p0 = pulsos;
        repete(4'b0100, 1'b1, 10);
        ciclo(4'b0000, 1'b1);
        ciclo(4'b0100, 1'b1);
        repete(4'b0000, 1'b1, 8);
        confere("glitch_pulsos", 32'(pulsos - p0), 32'd1);

        // habilita low: tracked but not reported
        p0 = pulsos;
        repete(4'b1000, 1'b0, 10);
        repete(4'b0000, 1'b1, 6);
        confere("hab0_pulsos", 32'(pulsos - p0), 32'd0);
        confere("hab0_jogada", 32'(jogada), 32'b0100);

        // reset while filtering
        repete(4'b0010, 1'b1, 3);
        confere("pre_reset_filtra", 32'(db_estado), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        botoes = '0;
        #1;
        confere_zerado("reset_meio");
        modelo_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        p0 = pulsos;
        repete(4'b0000, 1'b1, 10);
        confere("pos_reset_pulsos", 32'(pulsos - p0), 32'd0);

        // long hold for stuck-button flag
        repete(4'b0001, 1'b1, 1100);
        confere("preso_fim", 32'(botao_preso), 32'(PRESO_EN));
        repete(4'b0000, 1'b1, 8);
        confere("preso_solto", 32'(botao_preso), 32'd0);

        // randomized bursts
        for (int k = 0; k < 160; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)      v = '0;
            else if (r < 7) v = 4'(1 << $urandom_range(0, 3));
            else            v = 4'($urandom_range(1, 15));
            repete(v, ($urandom_range(0, 7) != 0), $urandom_range(1, 8));
        end
        repete(4'b0000, 1'b1, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
- Input-conditioning stage directly upstream of the memory-game datapath/control unit.
- Synchronises and debounces the raw push-button vector.
- Emits a registered play code plus a single-cycle "play made" pulse that feeds the game's jogada register and tem_jogada edge logic.
- Also reports multi-button presses so the downstream comparator can treat them as wrong plays.

Parameters:
- N_BOTOES, 4, number of buttons (width of botoes and jogada).
- DEBOUNCE_CICLOS, 3, consecutive identical synchronized samples required to accept a press or a release (3 ms at 1 kHz).
- PRESO_CICLOS, 1000, hold length that flags a stuck button (used only with the optional feature).

Ports:
- clock  in  1  system clock, 1 kHz nominal.
- reset  in  1  asynchronous, active-low reset.
- habilita  in  1  1 = presses reported; 0 = presses tracked but pulse suppressed.
- botoes  in  N_BOTOES  raw asynchronous button levels, 1 = pressed.
- tem_jogada  out  1  one-cycle pulse when a debounced press is accepted.
- jogada  out  N_BOTOES  accepted button vector, held until the next accepted press.
- multipla  out  1  1 if the last accepted jogada is not one-hot; updated with tem_jogada.
- db_estado  out  3  FSM state code for the 7-segment debug display.
- botao_preso  out  1  stuck-button flag (tied 0 when the feature is absent).

Behaviour:
- Reset (reset=0, async), all outputs 0:
  - tem_jogada=0, jogada=0, multipla=0, db_estado=0, botao_preso=0.
  - FSM to ESPERA, counters 0, synchronizer flops 0.
  - Reset asserted mid-operation aborts everything; no pulse follows deassertion unless a new press is qualified from scratch.
- Synchronizer: 2 flops per bit; s2 is the only value the FSM sees.
- FSM states (db_estado): ESPERA=0, FILTRA=1, VALIDA=2, SEGURA=3.
- ESPERA:
  - s2!=0 -> FILTRA, amostra<=s2, cnt<=1.
- FILTRA:
  - s2==amostra -> cnt++; when cnt reaches DEBOUNCE_CICLOS -> VALIDA.
  - s2==0 -> ESPERA.
  - s2 is a different nonzero vector -> stay in FILTRA, amostra<=s2, cnt<=1 (restart).
- VALIDA (exactly one cycle):
  - tem_jogada=1 and jogada<=amostra only if habilita=1.
  - multipla<=(popcount(amostra)>1), same condition.
  - Then SEGURA, cnt<=0.
  - habilita=0: no pulse, jogada/multipla unchanged, still proceeds to SEGURA.
- SEGURA:
  - s2==0 -> cnt++; s2!=0 -> cnt<=0.
  - cnt reaching DEBOUNCE_CICLOS -> ESPERA.
  - No new pulse is possible before a debounced release, including when a different button is pressed while held.
- Latency:
  - Clean press applied before rising edge 1 -> tem_jogada high from edge 2+DEBOUNCE_CICLOS (edge 5 at default) to the next edge.
  - Release requires DEBOUNCE_CICLOS zero samples after the sync delay.
- tem_jogada is registered; it is never high in two consecutive cycles.
- Minimum spacing between pulses: 2*DEBOUNCE_CICLOS+1 cycles.
- Counter width: clog2(max(DEBOUNCE_CICLOS,PRESO_CICLOS)+1). Counters saturate and do not wrap.

Optional Feature:
- Macro: BOTAO_PRESO_EN.
- Defined:
  - A second counter increments every cycle in SEGURA while s2!=0 and clears on ESPERA.
  - botao_preso<=1 when it reaches PRESO_CICLOS.
  - botao_preso clears on the transition to ESPERA or on reset.
- Undefined: counter absent; botao_preso tied 0.

Decomposition:
- Shared package condicionador_pkg:
  - State enum/localparams ESPERA..SEGURA and their 3-bit codes.
  - Default N_BOTOES and DEBOUNCE_CICLOS constants.
- One sub-module: sincronizador_2ff, parameterized width, async active-low reset to 0; instantiated once for botoes.

Test Plan:
- botoes=0001 applied at negedge, held 10 cycles, then 0 -> exactly one tem_jogada pulse at edge 5 after apply; jogada=0001, multipla=0; db_estado sequence 0,1,2,3,0.
- Bounce: 0010 for 2 cycles, 0000 for 1, 0010 for 10 -> single pulse 5 edges after the final 0010 onset; jogada=0010.
- botoes=1111 held 10 cycles -> one pulse, jogada=1111, multipla=1; next press 0100 -> multipla=0.
- Release glitch: 0100 held 10 cycles, then 0000/0100/0000 pattern with a 1-cycle glitch -> no second pulse; ESPERA is reached only after 3 consecutive zero samples.
- habilita=0 during a 1000 press -> no pulse, jogada keeps its previous value. reset=0 pulsed while in FILTRA -> all outputs 0 immediately, no pulse afterwards.
- With BOTAO_PRESO_EN, 0001 held 1100 cycles -> botao_preso=1 once PRESO_CICLOS=1000 cycles have elapsed in SEGURA, cleared on debounced release; without the macro, botao_preso stays 0.
